// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and helpers for the nff synchronizer/filter
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_LEN_MAX    = 255;

  // Smallest r with 2**r >= v; constant-evaluable for parameter sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_nff_chan.sv
// rtl/sync_nff_chan.sv - one channel: N-flop synchronizer, stability filter, edge pulses
module sync_nff_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   FILT_LEN  = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_sync,
  input  logic rst_n,
  input  logic data_in,
  output logic data_sync_out,
  output logic rise_out,
  output logic fall_out,
  output logic edge_next
);

  localparam int             CW     = clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(FILT_LEN - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] s;
  logic          sync;
  logic [CW-1:0] c;
  logic          commit;

  assign sync      = s[STAGES-1];
  assign commit    = (sync != data_sync_out) && (c == C_LAST);
  assign edge_next = commit;

  always_ff @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      s <= {STAGES{RESET_VAL}};
    end else begin
      s <= {s[STAGES-2:0], data_in};
    end
  end

  // c counts consecutive mismatches; a single matching cycle discards the run.
  always_ff @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_out <= RESET_VAL;
      c             <= '0;
      rise_out      <= 1'b0;
      fall_out      <= 1'b0;
    end else begin
      if (sync == data_sync_out) begin
        c <= '0;
      end else if (c == C_LAST) begin
        data_sync_out <= sync;
        c             <= '0;
      end else begin
        c <= c + CW'(1);
      end
      rise_out <= commit & sync;
      fall_out <= commit & ~sync;
    end
  end

endmodule

// File: rtl/sync_nff_filter.sv
// rtl/sync_nff_filter.sv - WIDTH independent synchronized, filtered, edge-detected inputs
module sync_nff_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILT_LEN  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_sync,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_sync_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             any_edge_out
);

  generate
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_nff_filter: STAGES out of range");
    end
    if (FILT_LEN < 1 || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
      $error("sync_nff_filter: FILT_LEN out of range");
    end
  endgenerate

  logic [WIDTH-1:0] edge_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_nff_chan #(
      .STAGES    (STAGES),
      .FILT_LEN  (FILT_LEN),
      .RESET_VAL (RESET_VAL[i])
    ) u_chan (
      .clk_sync      (clk_sync),
      .rst_n         (rst_n),
      .data_in       (data_in[i]),
      .data_sync_out (data_sync_out[i]),
      .rise_out      (rise_out[i]),
      .fall_out      (fall_out[i]),
      .edge_next     (edge_next[i])
    );
  end

  // Registered from the commit terms so it lines up with the per-channel pulses.
  always_ff @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      any_edge_out <= 1'b0;
    end else begin
      any_edge_out <= |edge_next;
    end
  end

endmodule

// File: tb/tb_sync_nff_filter.sv
// tb/tb_sync_nff_filter.sv - scoreboard bench with window-based reference model
module tb_sync_nff_filter;
  import sync_pkg::*;

  localparam int               WIDTH     = 4;
  localparam int               STAGES    = 3;
  localparam int               FILT_LEN  = 3;
  localparam logic [WIDTH-1:0] RESET_VAL = 4'b0110;

  logic             clk_sync = 1'b0;
  logic             rst_n    = 1'b0;
  logic [WIDTH-1:0] data_in  = '0;
  logic [WIDTH-1:0] data_sync_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             any_edge_out;

  sync_nff_filter #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .FILT_LEN  (FILT_LEN),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk_sync      (clk_sync),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_sync_out (data_sync_out),
    .rise_out      (rise_out),
    .fall_out      (fall_out),
    .any_edge_out  (any_edge_out)
  );

  always #5 clk_sync = ~clk_sync;

  typedef struct packed {
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] samp_q[$];
  logic [WIDTH-1:0] sync_q[$];
  logic [WIDTH-1:0] m_f;
  int               errors = 0;
  int               checks = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    samp_q.delete();
    sync_q.delete();
    m_f    = RESET_VAL;
    e      = '0;
    e.lvl  = RESET_VAL;
    exp_q.push_back(e);
  endtask

  // The level changes once the last FILT_LEN synchronized samples all disagree with it.
  task automatic model_edge(input logic [WIDTH-1:0] d);
    exp_t             e;
    logic [WIDTH-1:0] sy;
    bit               all_diff;
    samp_q.push_back(d);
    sy = (samp_q.size() > STAGES) ? samp_q[samp_q.size() - 1 - STAGES] : RESET_VAL;
    if (samp_q.size() > STAGES) void'(samp_q.pop_front());
    sync_q.push_back(sy);
    if (sync_q.size() > FILT_LEN) void'(sync_q.pop_front());
    e = '0;
    for (int i = 0; i < WIDTH; i++) begin
      all_diff = (sync_q.size() == FILT_LEN);
      foreach (sync_q[k]) if (sync_q[k][i] == m_f[i]) all_diff = 0;
      if (all_diff) begin
        m_f[i]    = sy[i];
        e.rise[i] = sy[i];
        e.fall[i] = ~sy[i];
      end
    end
    e.lvl = m_f;
    e.any = |(e.rise | e.fall);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [WIDTH-1:0] d);
    @(negedge clk_sync);
    data_in = d;
    if (rst) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
      model_edge(d);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_sync);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_sync_out", data_sync_out, e.lvl);
        check("rise_out", rise_out, e.rise);
        check("fall_out", fall_out, e.fall);
        check("any_edge_out", {{(WIDTH-1){1'b0}}, any_edge_out}, {{(WIDTH-1){1'b0}}, e.any});
      end
    end
  end

  initial begin : stimulus
    logic [WIDTH-1:0] cur;
    for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'($urandom));
    cur = RESET_VAL;
    for (int i = 0; i < 10; i++) drive(1'b0, cur);
    // Pulses of growing length straddling the filter threshold.
    for (int len = 1; len <= FILT_LEN + 2; len++) begin
      for (int i = 0; i < len; i++) drive(1'b0, cur ^ 4'b0101);
      for (int i = 0; i < 10; i++) drive(1'b0, cur);
    end
    // Glitch on channel 1 while channels 0 and 2 step together.
    cur = cur ^ 4'b0101;
    drive(1'b0, cur ^ 4'b0010);
    drive(1'b0, cur);
    for (int i = 0; i < 12; i++) drive(1'b0, cur);
    // Reset landing mid-count, then the full latency again.
    cur = ~cur;
    for (int i = 0; i < STAGES + FILT_LEN - 2; i++) drive(1'b0, cur);
    drive(1'b1, cur);
    for (int i = 0; i < STAGES + FILT_LEN + 4; i++) drive(1'b0, cur);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < WIDTH; i++) if ($urandom_range(4) == 0) cur[i] = ~cur[i];
      drive($urandom_range(299) == 0, cur);
    end
    for (int i = 0; i < 10; i++) drive(1'b0, cur);
    repeat (3) @(posedge clk_sync);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
